// File: rtl/count_sequencer_if.sv
// Handshake/data bundle between a count_sequencer and whatever drives it.
// The master drives the controls and the slave drives the registered count and status.
interface count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start_i;
    logic             stop_i;
    logic             en_i;
    logic [1:0]       mode_i;
    logic             dir_i;
    logic [WIDTH-1:0] load_val_i;
    logic [WIDTH-1:0] term_val_i;
    logic [WIDTH-1:0] data_o;
    logic             busy_o;
    logic             done_o;
    logic             wrap_o;

    modport master (
        output start_i, stop_i, en_i, mode_i, dir_i, load_val_i, term_val_i,
        input  data_o, busy_o, done_o, wrap_o
    );

    modport slave (
        input  start_i, stop_i, en_i, mode_i, dir_i, load_val_i, term_val_i,
        output data_o, busy_o, done_o, wrap_o
    );
endinterface

// File: rtl/count_sequencer.sv
// Start/stop count sequencer: counts from a captured load value toward a captured terminal
// value in one of three modes: stop once, reload, or bounce between the two endpoints.
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    count_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       M_RELOAD   = 2'b01;
    localparam logic [1:0]       M_PINGPONG = 2'b10;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    state_t           state_q;
    logic [1:0]       mode_q;
    logic             dir_q;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] target_q;
    logic             busy_q;
    logic             done_q;
    logic             wrap_q;

    logic             at_target;
    logic [WIDTH-1:0] step_fwd_d;
    logic [WIDTH-1:0] step_rev_d;

    // Steps wrap modulo 2^WIDTH; the reversed step is what a PINGPONG turnaround takes.
    assign at_target  = (count_q == target_q);
    assign step_fwd_d = dir_q ? (count_q + ONE) : (count_q - ONE);
    assign step_rev_d = dir_q ? (count_q - ONE) : (count_q + ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'b00;
            dir_q    <= 1'b0;
            load_q   <= '0;
            term_q   <= '0;
            count_q  <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        mode_q   <= bus.mode_i;
                        dir_q    <= bus.dir_i;
                        load_q   <= bus.load_val_i;
                        term_q   <= bus.term_val_i;
                        count_q  <= bus.load_val_i;
                        target_q <= bus.term_val_i;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end

                S_RUN: begin
                    // Abort wins over any terminal event in the same cycle.
                    if (bus.stop_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (bus.en_i) begin
                        if (!at_target) begin
                            count_q <= step_fwd_d;
                        end else begin
                            case (mode_q)
                                M_RELOAD: begin
                                    count_q <= load_q;
                                    wrap_q  <= 1'b1;
                                end
                                M_PINGPONG: begin
                                    wrap_q <= 1'b1;
                                    // Degenerate span (load==term) just parks and keeps pulsing.
                                    if (load_q != term_q) begin
                                        dir_q    <= ~dir_q;
                                        target_q <= (target_q == term_q) ? load_q : term_q;
                                        count_q  <= step_rev_d;
                                    end
                                end
                                default: begin
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end
                            endcase
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_o = count_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.wrap_o = wrap_q;
endmodule

// File: tb/tb_count_sequencer.sv
// Directed, table-driven bench for count_sequencer plus hand sequences for reset corners.
module tb_count_sequencer;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    count_sequencer_if #(.WIDTH(W)) bus ();

    count_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         s, p, e;
        logic [1:0]   m;
        logic         dr;
        logic [W-1:0] ld, tm;
        logic [W-1:0] d;
        logic         b, dn, w;
    } vec_t;

    vec_t tbl[$];
    int   total  = 0;
    int   passed = 0;

    function automatic vec_t V(bit s, bit p, bit e, bit [1:0] m, bit dr, int ld, int tm,
                               int d, bit b, bit dn, bit w);
        vec_t v;
        v.s = s; v.p = p; v.e = e; v.m = m; v.dr = dr;
        v.ld = ld[W-1:0]; v.tm = tm[W-1:0]; v.d = d[W-1:0];
        v.b = b; v.dn = dn; v.w = w;
        return v;
    endfunction

    task automatic chk(string nm, int idx, int got, int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s step %0d: got %0d want %0d", nm, idx, got, want);
    endtask

    task automatic chk_all(int idx, int d, bit b, bit dn, bit w);
        chk("data_o", idx, int'(bus.data_o), d);
        chk("busy_o", idx, int'(bus.busy_o), int'(b));
        chk("done_o", idx, int'(bus.done_o), int'(dn));
        chk("wrap_o", idx, int'(bus.wrap_o), int'(w));
    endtask

    task automatic drive(bit s, bit p, bit e, bit [1:0] m, bit dr, int ld, int tm);
        bus.start_i    = s;
        bus.stop_i     = p;
        bus.en_i       = e;
        bus.mode_i     = m;
        bus.dir_i      = dr;
        bus.load_val_i = ld[W-1:0];
        bus.term_val_i = tm[W-1:0];
    endtask

    initial begin
        //             s p e m     d ld tm   data b dn w
        // ONESHOT up 3->6
        tbl.push_back(V(1,0,1,2'b00,1, 3, 6,   3, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1, 3, 6,   4, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1, 3, 6,   5, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1, 3, 6,   6, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1, 3, 6,   6, 1,1,0));
        tbl.push_back(V(0,0,1,2'b00,1, 3, 6,   6, 0,0,0));
        tbl.push_back(V(0,1,1,2'b01,0, 9, 2,   6, 0,0,0));
        // RELOAD down 1->14, inputs scrambled after capture
        tbl.push_back(V(1,0,1,2'b01,0, 1,14,   1, 1,0,0));
        tbl.push_back(V(0,0,1,2'b10,1, 5, 5,   0, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1, 5, 5,  15, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1, 5, 5,  14, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1, 5, 5,   1, 1,0,1));
        tbl.push_back(V(0,0,1,2'b00,1, 5, 5,   0, 1,0,0));
        tbl.push_back(V(0,1,1,2'b00,1, 5, 5,   0, 0,0,0));
        // PINGPONG up 2<->4
        tbl.push_back(V(1,0,1,2'b10,1, 2, 4,   2, 1,0,0));
        tbl.push_back(V(0,0,1,2'b10,1, 2, 4,   3, 1,0,0));
        tbl.push_back(V(0,0,1,2'b10,1, 2, 4,   4, 1,0,0));
        tbl.push_back(V(0,0,1,2'b10,1, 2, 4,   3, 1,0,1));
        tbl.push_back(V(0,0,1,2'b10,1, 2, 4,   2, 1,0,0));
        tbl.push_back(V(0,0,1,2'b10,1, 2, 4,   3, 1,0,1));
        tbl.push_back(V(0,0,1,2'b10,1, 2, 4,   4, 1,0,0));
        tbl.push_back(V(0,0,1,2'b10,1, 2, 4,   3, 1,0,1));
        tbl.push_back(V(0,1,1,2'b10,1, 2, 4,   3, 0,0,0));
        // mode 11 as ONESHOT, en gaps, stop coincident with terminal
        tbl.push_back(V(1,0,0,2'b11,1, 5, 7,   5, 1,0,0));
        tbl.push_back(V(0,0,1,2'b11,1, 5, 7,   6, 1,0,0));
        tbl.push_back(V(0,0,0,2'b11,1, 5, 7,   6, 1,0,0));
        tbl.push_back(V(0,0,0,2'b11,1, 5, 7,   6, 1,0,0));
        tbl.push_back(V(0,0,1,2'b11,1, 5, 7,   7, 1,0,0));
        tbl.push_back(V(0,1,1,2'b11,1, 5, 7,   7, 0,0,0));
        tbl.push_back(V(0,0,1,2'b11,1, 5, 7,   7, 0,0,0));
        // PINGPONG with load==term
        tbl.push_back(V(1,0,1,2'b10,0, 9, 9,   9, 1,0,0));
        tbl.push_back(V(0,0,1,2'b10,0, 9, 9,   9, 1,0,1));
        tbl.push_back(V(0,0,0,2'b10,0, 9, 9,   9, 1,0,0));
        tbl.push_back(V(0,0,1,2'b10,0, 9, 9,   9, 1,0,1));
        tbl.push_back(V(0,1,1,2'b10,0, 9, 9,   9, 0,0,0));
        // ONESHOT up across 15->0, then start held through DONE
        tbl.push_back(V(1,0,1,2'b00,1,15, 1,  15, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1,15, 1,   0, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1,15, 1,   1, 1,0,0));
        tbl.push_back(V(0,0,1,2'b00,1,15, 1,   1, 1,1,0));
        tbl.push_back(V(1,0,1,2'b00,1, 8, 8,   1, 0,0,0));
        tbl.push_back(V(1,0,1,2'b00,1, 8, 8,   8, 1,0,0));
        tbl.push_back(V(1,0,1,2'b00,1, 8, 8,   8, 1,1,0));
        tbl.push_back(V(1,0,1,2'b01,1, 3, 3,   8, 0,0,0));
        tbl.push_back(V(1,0,1,2'b01,1, 3, 3,   3, 1,0,0));
        tbl.push_back(V(0,0,1,2'b01,1, 3, 3,   3, 1,0,1));
        tbl.push_back(V(0,1,1,2'b01,1, 3, 3,   3, 0,0,0));

        drive(0, 0, 0, 2'b00, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_all(-1, 0, 0, 0, 0);
        #12 rst_n = 1'b1;

        // Out of reset with en high and start low: nothing moves.
        @(negedge clk); drive(0, 0, 1, 2'b01, 1, 7, 3);
        @(posedge clk); #1; chk_all(-2, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].s, tbl[i].p, tbl[i].e, tbl[i].m, tbl[i].dr, int'(tbl[i].ld), int'(tbl[i].tm));
            @(posedge clk); #1;
            chk_all(i, int'(tbl[i].d), tbl[i].b, tbl[i].dn, tbl[i].w);
        end

        // RELOAD up with start held high in RUN, then asynchronous reset at count 9.
        @(negedge clk); drive(1, 0, 1, 2'b01, 1, 7, 12);
        @(posedge clk); #1; chk_all(100, 7, 1, 0, 0);
        @(negedge clk); drive(1, 0, 1, 2'b01, 1, 0, 0);
        @(posedge clk); #1; chk_all(101, 8, 1, 0, 0);
        @(negedge clk); drive(1, 0, 1, 2'b00, 0, 2, 2);
        @(posedge clk); #1; chk_all(102, 9, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1; chk_all(103, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 1, 2'b01, 1, 7, 12); rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1; chk_all(104 + k, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  level-sampled start request, honoured in IDLE only.
REQ-005 stop_i  input  1  abort request, honoured in RUN only.
REQ-006 en_i  input  1  step enable; the count advances only on cycles with en_i=1.
REQ-007 mode_i  input  2  sequence mode: 00 ONESHOT, 01 RELOAD, 10 PINGPONG, 11 treated as ONESHOT.
REQ-008 dir_i  input  1  initial direction: 1 up, 0 down.
REQ-009 load_val_i  input  WIDTH  start value.
REQ-010 term_val_i  input  WIDTH  terminal value.
REQ-011 data_o  output  WIDTH  current count, registered.
REQ-012 busy_o  output  1  high in RUN and DONE.
REQ-013 done_o  output  1  one-cycle pulse on ONESHOT completion.
REQ-014 wrap_o  output  1  one-cycle pulse on each RELOAD or PINGPONG terminal event.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE, with all outputs registered.
REQ-016 IDLE with start_i=1: capture mode, dir, load and term values into internal registers; count<=load_val_i; target<=term_val_i; next state RUN.
REQ-017 Input changes after capture SHALL NOT affect the running sequence.
REQ-018 RUN, en_i=1, count!=target: count steps +1 (dir up) or -1 (dir down) modulo 2^WIDTH, so 15->0 up and 0->15 down.
REQ-019 RUN, en_i=0: count, dir and target hold.
REQ-020 RUN, en_i=1, count==target, ONESHOT: count holds; next state DONE.
REQ-021 RUN, en_i=1, count==target, RELOAD: count<=captured load; wrap_o=1 next cycle; stay RUN.
REQ-022 RUN, en_i=1, count==target, PINGPONG, load!=term: reverse dir; swap target between load and term; count steps one in the new direction in the same cycle; wrap_o pulses.
REQ-023 PINGPONG with load==term: count holds; wrap_o pulses on every enabled cycle.
REQ-024 ONESHOT and RELOAD with load==term: the terminal action occurs on the first enabled cycle.
REQ-025 DONE: done_o=1 for exactly one cycle; next state IDLE; count holds the term value.
REQ-026 stop_i in RUN: next state IDLE; count holds; no done or wrap pulse; stop_i overrides a coincident terminal event.
REQ-027 start_i outside IDLE is ignored; stop_i outside RUN is ignored.
REQ-028 start_i held high after DONE->IDLE re-captures and starts a new sequence; IDLE->RUN latency is 1 cycle.
REQ-029 In IDLE, data_o retains its last value until the next start.

Reset
REQ-030 rst_n=0 at any time, including mid-sequence: immediate (asynchronous) state IDLE, count=0, dir register=0, target=0, busy_o=0, done_o=0, wrap_o=0.
REQ-031 After rst_n deasserts, the block SHALL take no action until start_i is sampled high in IDLE.

Verification
REQ-032 ONESHOT, up, load=3, term=6, en_i=1 continuous: data_o 3,4,5,6,6; done_o high exactly one cycle; busy_o low thereafter.
REQ-033 RELOAD, down, load=1, term=14: data_o 1,0,15,14,1,0,...; wrap_o pulses at each 14->1 transition.
REQ-034 PINGPONG, up, load=2, term=4: data_o 2,3,4,3,2,3,4; wrap_o pulses on the cycles data_o leaves 4 and leaves 2.
REQ-035 en_i toggled 1,0,0,1 during RUN: count holds on the disabled cycles; stop_i asserted together with count==term in ONESHOT: IDLE, no done_o.
REQ-036 rst_n pulsed low mid-RELOAD with count=9: data_o=0 and busy_o=0 without a clock edge; start_i held high during RUN: no re-capture.
